// File: rtl/enable_register_pkg.sv
// Shared definitions for the enable_register block: default width and the
// word-parity helper used by the optional parity output.
package enable_register_pkg;

  // Width used when the instantiating block does not override WIDTH.
  localparam int REG_DEFAULT_WIDTH = 4;

  // Widest word the register supports. Narrower words are zero-extended
  // before parity_of() is applied, and zero bits do not change XOR parity.
  localparam int REG_MAX_WIDTH = 64;

  // Even parity of a word: the XOR of all of its bits.
  function automatic logic parity_of(input logic [REG_MAX_WIDTH-1:0] word);
    logic r_acc;
    r_acc = 1'b0;
    for (int i = 0; i < REG_MAX_WIDTH; i++) begin
      r_acc = r_acc ^ word[i];
    end
    return r_acc;
  endfunction

endpackage

// File: rtl/enable_register_bit.sv
// One-bit storage cell of enable_register: synchronous active-low reset to a
// per-bit reset value, otherwise load on enable, otherwise hold.
module enable_register_bit (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  input  logic d_bit,
  input  logic rst_bit,
  output logic q_bit
);

  logic r_q;

  // Reset has priority over enable; reset is only seen on the rising edge.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_q <= rst_bit;
    end else if (enable) begin
      r_q <= d_bit;
    end else begin
      r_q <= r_q;
    end
  end

  assign q_bit = r_q;

endmodule

// File: rtl/enable_register.sv
// WIDTH-bit loadable, clearable register built from enable_register_bit
// cells. q is a pure flop output; there is no path from d to q.
// Optional feature: define ENABLE_REGISTER_PARITY_EN to add q_parity, a
// registered even parity of the stored word following the same
// reset/enable rules as q.
module enable_register
  import enable_register_pkg::*;
#(
  parameter int               WIDTH       = REG_DEFAULT_WIDTH,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
`ifdef ENABLE_REGISTER_PARITY_EN
  ,
  output logic             q_parity
`endif
);

  logic [WIDTH-1:0] w_q;

  // One storage cell per bit, each with its own reset value bit.
  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    enable_register_bit u_bit (
      .clk     (clk),
      .reset   (reset),
      .enable  (enable),
      .d_bit   (d[i]),
      .rst_bit (RESET_VALUE[i]),
      .q_bit   (w_q[i])
    );
  end

  assign q = w_q;

`ifdef ENABLE_REGISTER_PARITY_EN
  logic [REG_MAX_WIDTH-1:0] w_d_wide;
  logic [REG_MAX_WIDTH-1:0] w_rv_wide;
  logic                     r_parity;

  // Zero-extend the incoming word and the reset value for the parity helper.
  always_comb begin
    w_d_wide               = {REG_MAX_WIDTH{1'b0}};
    w_rv_wide              = {REG_MAX_WIDTH{1'b0}};
    w_d_wide[WIDTH-1:0]    = d;
    w_rv_wide[WIDTH-1:0]   = RESET_VALUE;
  end

  // Parity is computed from d and registered alongside q, so it tracks q
  // on exactly the same edges.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_parity <= parity_of(w_rv_wide);
    end else if (enable) begin
      r_parity <= parity_of(w_d_wide);
    end else begin
      r_parity <= r_parity;
    end
  end

  assign q_parity = r_parity;
`endif

endmodule

// File: tb/tb_enable_register.sv
// Directed testbench for enable_register with a scoreboard queue: each step
// pushes its expected result when stimulus is driven and pops it when the
// output is sampled after the clock edge.
module tb_enable_register;

  localparam int W = 4;

  typedef struct {
    logic [W-1:0] q;
    logic         p;
  } exp_t;

  logic         clk;
  logic         reset;
  logic         enable;
  logic [W-1:0] d;
  logic [W-1:0] q;
`ifdef ENABLE_REGISTER_PARITY_EN
  logic         q_parity;
`endif

  exp_t sb[$];
  int   total;
  int   bad;

  enable_register #(
    .WIDTH       (W),
    .RESET_VALUE (4'b0000)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .enable   (enable),
    .d        (d),
    .q        (q)
`ifdef ENABLE_REGISTER_PARITY_EN
    ,
    .q_parity (q_parity)
`endif
  );

  // 10 time-unit clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pop the oldest expectation and compare it with the outputs.
  task automatic check(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      total++;
      bad++;
      $error("FAIL %s: scoreboard empty, q=%b", tag, q);
    end else begin
      e = sb.pop_front();
      total++;
      assert (q === e.q) else begin
        bad++;
        $error("FAIL %s: q=%b expected %b", tag, q, e.q);
      end
`ifdef ENABLE_REGISTER_PARITY_EN
      total++;
      assert (q_parity === e.p) else begin
        bad++;
        $error("FAIL %s_parity: q_parity=%b expected %b", tag, q_parity, e.p);
      end
`endif
    end
  endtask

  // Drive one cycle of stimulus at the falling edge, record the expected
  // result, then sample just after the following rising edge.
  task automatic step(input logic rst_v, input logic en_v, input logic [W-1:0] d_v,
                      input logic [W-1:0] exp_q, input string tag);
    exp_t e;
    @(negedge clk);
    reset  = rst_v;
    enable = en_v;
    d      = d_v;
    e.q    = exp_q;
    e.p    = ^exp_q;
    sb.push_back(e);
    @(posedge clk);
    #1;
    check(tag);
  endtask

  // Guard against a hung run.
  initial begin
    #20000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;
    logic [W-1:0] iv;
    total  = 0;
    bad    = 0;
    reset  = 1'b0;
    enable = 1'b0;
    d      = 4'b0000;

    // Reset with enable low.
    step(1'b0, 1'b0, 4'b0000, 4'b0000, "reset_state");

    // Load sweep, then reset must beat enable.
    for (int i = 0; i < 16; i++) begin
      iv = 4'(i);
      step(1'b1, 1'b1, iv, iv, "load_sweep");
    end
    step(1'b0, 1'b1, 4'b1111, 4'b0000, "reset_beats_enable");

    // Hold sweep with q at zero.
    for (int i = 0; i < 16; i++) begin
      iv = 4'(i);
      step(1'b1, 1'b0, iv, 4'b0000, "hold_sweep");
    end
    step(1'b0, 1'b0, 4'b1111, 4'b0000, "hold_reset");

    // Hold of a nonzero value.
    step(1'b1, 1'b1, 4'b1010, 4'b1010, "load_1010");
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b0, 4'b0101, 4'b1010, "hold_1010");
    end

    // Reset pulse between edges must not disturb q.
    step(1'b1, 1'b1, 4'b0110, 4'b0110, "load_0110");
    @(negedge clk);
    enable = 1'b0;
    d      = 4'b1111;
    reset  = 1'b0;
    #2;
    e.q = 4'b0110;
    e.p = 1'b0;
    sb.push_back(e);
    check("mid_cycle_reset");
    reset = 1'b1;
    e.q = 4'b0110;
    e.p = 1'b0;
    sb.push_back(e);
    @(posedge clk);
    #1;
    check("after_reset_pulse");
    step(1'b0, 1'b0, 4'b1111, 4'b0000, "reset_across_edge");

    // Parity-oriented loads (q checked always, parity when present).
    step(1'b1, 1'b1, 4'b0111, 4'b0111, "load_0111");
    step(1'b1, 1'b1, 4'b0011, 4'b0011, "load_0011");
    step(1'b1, 1'b0, 4'b1000, 4'b0011, "hold_0011");
    step(1'b1, 1'b1, 4'b1101, 4'b1101, "load_1101");
    step(1'b0, 1'b1, 4'b0001, 4'b0000, "reset_parity");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
